siso_link_arbiter: RTL and testbench
====================================

Name: siso_link_arbiter

Overview:
- Shares one N-bit SISO shift register among NREQ requesters.
- Round-robin arbitration: one requester's WIDTH-bit word is shifted into the SISO LSB first, and the emerging bitstream is captured back into a parallel word.
- The captured word is returned to the requester with a loopback-mismatch flag.
- Sits between the requesters and the SISO instance, driving its serial_in and sampling its serial_out.

Parameters:
- NREQ, 4, number of requesters (>=2)
- WIDTH, 4, payload bits per transfer
- DEPTH, 4, stage count of the attached SISO (serial_out = serial_in delayed DEPTH clocks)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request level
- req_data  input  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot, one-cycle grant pulse
- busy  output  1  high whenever state != IDLE
- sr_in  output  1  drives SISO serial_in (registered)
- sr_out  input  1  from SISO serial_out
- done  output  1  one-cycle completion pulse
- done_id  output  $clog2(NREQ)  index of completed requester, valid with done
- rx_data  output  WIDTH  captured word, valid with done
- err  output  1  rx_data != transmitted word, valid with done

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE. gnt, busy, sr_in, done, done_id, rx_data, err all clear to 0.
  - Round-robin pointer resets to NREQ-1, so req[0] has top priority after reset.
  - Reset mid-transfer aborts it: no done pulse, no grant carried over.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - At any edge with req != 0, select the first asserted req scanning from pointer+1 mod NREQ, upward with wrap.
  - At that edge: latch its req_data into tx word, latch its id, update pointer to the id, move to SHIFT with cnt=0.
  - req == 0: remain in IDLE, sr_in=0.
- SHIFT:
  - Lasts WIDTH+DEPTH cycles, cnt = 0..WIDTH+DEPTH-1.
  - gnt[id] is high only during cnt=0.
  - sr_in = tx[cnt] when cnt < WIDTH, else 0. sr_in is registered and changes only at edges.
  - At the end of each cycle with cnt >= DEPTH, rx bit (cnt-DEPTH) <= sr_out.
  - After cnt = WIDTH+DEPTH-1, move to DONE.
- DONE (one cycle):
  - done=1, done_id=id, rx_data=captured word, err=(captured != tx).
  - Next state is IDLE.
  - rx_data, done_id and err hold their values until the next done.
- Handshake:
  - Requester holds req and req_data stable until it sees gnt. Data is sampled at the arbitration edge, i.e. the edge before gnt.
  - A requester may drop req during or after gnt. If req is still high in the next IDLE, it re-enters round-robin after the other requesters.
  - req changes while busy are ignored.
  - A req withdrawn before arbitration is never granted.
- Timing:
  - gnt to done = WIDTH+DEPTH cycles.
  - Back-to-back transfer period = WIDTH+DEPTH+2 cycles (SHIFT + DONE + IDLE).
- Width rule: cnt width = $clog2(WIDTH+DEPTH+1). There is no wrap inside a transfer.
- Simultaneous requests: exactly one grant per IDLE arbitration. gnt is never multi-hot.

Test Plan:
- Single transfer: NREQ=4, WIDTH=4, DEPTH=4; req[1]=1, req_data[7:4]=4'b1011.
  - gnt=4'b0010 for one cycle.
  - sr_in sequence 1,1,0,1,0,0,0,0 starting in the gnt cycle.
  - done 8 cycles after gnt with done_id=1, rx_data=4'hB, err=0.
- Round-robin: req=4'b1111 held continuously.
  - Grants in order 0,1,2,3,0, each 10 cycles apart.
  - busy stays low for exactly 1 cycle between transfers.
- Mismatch: bench forces sr_out=0; req[2] with data 4'hB -> done_id=2, rx_data=4'h0, err=1.
- Reset mid-transfer: assert rst=0 during SHIFT cnt=3.
  - All outputs go to 0 immediately and no done is seen.
  - After release, with req=4'b1010, req[1] is granted first.
- Busy lockout: req[3] rises while a req[0] transfer is in SHIFT.
  - No gnt until the following IDLE, then gnt=4'b1000.
  - req[3] words 4'h0 and 4'hF round-trip with err=0.

Source files
------------

// File: rtl/siso_link_arbiter.sv
// Round-robin arbiter that lends one external SISO shift register to NREQ requesters,
// shifting each granted word through it LSB first and returning the looped-back capture.
module siso_link_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      sr_in,
    input  logic                      sr_out,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic [WIDTH-1:0]          rx_data,
    output logic                      err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH + DEPTH + 1);
    localparam logic [CW-1:0] FIRST_CAP = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT  = CW'(WIDTH + DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     id_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  tx_q;
    logic [WIDTH-1:0]  sh_q;
    logic [WIDTH-1:0]  rx_q;
    logic [NREQ-1:0]   gnt_q;
    logic              busy_q;
    logic              sr_in_q;
    logic              done_q;
    logic [IW-1:0]     done_id_q;
    logic [WIDTH-1:0]  rx_data_q;
    logic              err_q;

    logic              found_d;
    logic [IW-1:0]     sel_d;
    logic [IW-1:0]     cand;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  sh_next;
    logic [WIDTH:0]    rx_ext;
    logic [WIDTH-1:0]  rx_next;

    // Scan starts just after the last winner, so the previous grantee goes last.
    always_comb begin
        found_d = 1'b0;
        sel_d   = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IW'((32'(ptr_q) + i) % NREQ);
            if (!found_d && req[cand]) begin
                found_d = 1'b1;
                sel_d   = cand;
            end
        end
        sel_data = req_data[32'(sel_d)*WIDTH +: WIDTH];
        sh_next  = sh_q >> 1;
        rx_ext   = {sr_out, rx_q};
        rx_next  = rx_ext[WIDTH:1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NREQ - 1);
            id_q      <= '0;
            cnt_q     <= '0;
            tx_q      <= '0;
            sh_q      <= '0;
            rx_q      <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            sr_in_q   <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            rx_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sr_in_q <= 1'b0;
                    if (found_d) begin
                        tx_q    <= sel_data;
                        sh_q    <= sel_data;
                        sr_in_q <= sel_data[0];
                        id_q    <= sel_d;
                        ptr_q   <= sel_d;
                        gnt_q   <= NREQ'(1) << sel_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // sh_q drains to zero after WIDTH shifts, padding sr_in with 0s.
                    sh_q    <= sh_next;
                    sr_in_q <= sh_next[0];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q >= FIRST_CAP) begin
                        rx_q <= rx_next;
                    end
                    if (cnt_q == LAST_CNT) begin
                        done_q    <= 1'b1;
                        done_id_q <= id_q;
                        rx_data_q <= rx_next;
                        err_q     <= (rx_next != tx_q);
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    sr_in_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign sr_in   = sr_in_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign rx_data = rx_data_q;
    assign err     = err_q;

endmodule

// File: tb/tb_siso_link_arbiter.sv
// Directed bench for siso_link_arbiter with a behavioural SISO and a completion scoreboard.
module tb_siso_link_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic        sr_in;
    logic        sr_out;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  rx_data;
    logic        err;

    logic             force_zero = 1'b0;
    logic [DEPTH-1:0] siso = '0;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   pushed   = 0;

    siso_link_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .busy     (busy),
        .sr_in    (sr_in),
        .sr_out   (sr_out),
        .done     (done),
        .done_id  (done_id),
        .rx_data  (rx_data),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) siso <= {siso[DEPTH-2:0], sr_in};
    assign sr_out = force_zero ? 1'b0 : siso[DEPTH-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [3:0] d, input logic e);
        exp_t x;
        x.id = id; x.data = d; x.err = e;
        sb.push_back(x);
        pushed++;
    endtask

    task automatic wait_gnt(input logic [3:0] exp_g, input int budget, output int waited);
        waited = 0;
        while (waited < budget) begin
            @(negedge clk);
            waited++;
            if (gnt != 4'b0000) break;
        end
        chk("gnt_value", gnt, exp_g);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (busy == 1'b0) break;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},     gnt,     '0);
        chk({tag, "_busy"},    busy,    '0);
        chk({tag, "_sr_in"},   sr_in,   '0);
        chk({tag, "_done"},    done,    '0);
        chk({tag, "_done_id"}, done_id, '0);
        chk({tag, "_rx_data"}, rx_data, '0);
        chk({tag, "_err"},     err,     '0);
    endtask

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_has_expectation", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("done_id", done_id, mon_e.id);
                chk("rx_data", rx_data, mon_e.data);
                chk("err",     err,     mon_e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         w;
        int         cyc;
        int         idle;
        int         bad;
        int         dsnap;
        logic [7:0] seq;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Round robin from reset pointer: 0,1,2,3,0 every 10 cycles
        req_data = {4'hC, 4'h3, 4'hA, 4'h5};
        req      = 4'hF;
        push(2'd0, 4'h5, 1'b0);
        push(2'd1, 4'hA, 1'b0);
        push(2'd2, 4'h3, 1'b0);
        push(2'd3, 4'hC, 1'b0);
        push(2'd0, 4'h5, 1'b0);
        wait_gnt(4'b0001, 5, w);
        for (int k = 1; k <= 4; k++) begin
            cyc  = 0;
            idle = 0;
            while (cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (busy == 1'b0) idle++;
                if (gnt != 4'b0000) break;
            end
            chk("rr_gnt",    gnt,  4'b0001 << (k % 4));
            chk("rr_period", cyc,  10);
            chk("rr_idle",   idle, 1);
        end
        req = 4'b0000;
        wait_idle(20);

        // Single transfer: req[1] with 4'b1011
        req_data = 16'h00B0;
        req      = 4'b0010;
        push(2'd1, 4'hB, 1'b0);
        wait_gnt(4'b0010, 5, w);
        chk("single_busy", busy, 1'b1);
        chk("sr_in_bit0", sr_in, 1'b1);
        req = 4'b0000;
        seq = 8'b0000_1011;
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            chk("sr_in_seq", sr_in, seq[j]);
            if (j == 1) chk("gnt_one_cycle", gnt, 4'b0000);
        end
        @(negedge clk);
        chk("done_latency", done, 1'b1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("busy_low_after_done", busy, 1'b0);
        repeat (2) @(negedge clk);
        chk("rx_data_hold", rx_data, 4'hB);
        chk("done_id_hold", done_id, 2'd1);

        // Loopback mismatch with sr_out stuck low
        force_zero = 1'b1;
        req_data   = 16'h0B00;
        req        = 4'b0100;
        push(2'd2, 4'h0, 1'b1);
        wait_gnt(4'b0100, 5, w);
        req = 4'b0000;
        wait_idle(20);
        force_zero = 1'b0;
        @(negedge clk);

        // Busy lockout: req[3] rises during a req[0] transfer
        req_data = 16'h0006;
        req      = 4'b0001;
        push(2'd0, 4'h6, 1'b0);
        wait_gnt(4'b0001, 5, w);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        req_data = 16'h0000;
        req      = 4'b1000;
        push(2'd3, 4'h0, 1'b0);
        bad = 0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (gnt != 4'b0000) bad++;
            if (busy == 1'b0) break;
        end
        chk("lockout_no_gnt", bad, 0);
        wait_gnt(4'b1000, 3, w);
        chk("lockout_gnt_delay", w, 1);
        req_data = 16'hF000;
        push(2'd3, 4'hF, 1'b0);
        wait_gnt(4'b1000, 12, w);
        chk("lockout_regrant_period", w, 10);
        req = 4'b0000;
        wait_idle(20);
        @(negedge clk);

        // Reset at SHIFT cnt=3 aborts the transfer
        req_data = 16'h0009;
        req      = 4'b0001;
        wait_gnt(4'b0001, 5, w);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        dsnap = done_cnt;
        rst = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (8) @(negedge clk);
        chk("abort_no_done", done_cnt, dsnap);
        rst      = 1'b1;
        req_data = 16'h8070;
        req      = 4'b1010;
        push(2'd1, 4'h7, 1'b0);
        push(2'd3, 4'h8, 1'b0);
        wait_gnt(4'b0010, 5, w);
        wait_gnt(4'b1000, 12, w);
        chk("post_reset_period", w, 10);
        req = 4'b0000;
        wait_idle(20);
        repeat (2) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        chk("done_count", done_cnt, pushed);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
